// File: rtl/grf_write_demux.sv
// grf_write_demux: MIPS general register file built around a write-port demultiplexer.
//
// Purpose:
//   One write port decodes a destination index into one-hot write enables. Register 0 is
//   hardwired to zero. Two independent combinational read ports can optionally bypass
//   same-cycle write data. A registered trace reports every committed write.
//
// Ports:
//   clk       in   rising-edge clock
//   reset_n   in   asynchronous active-low reset; clears registers and trace outputs
//   we        in   write enable
//   wa        in   write index (demux select)
//   wd        in   write data
//   ra1, ra2  in   read indices
//   rd1, rd2  out  combinational read data
//   wb_valid  out  one-cycle pulse after a committed write
//   wb_addr   out  index of the last committed write
//   wb_data   out  data of the last committed write

module grf_write_demux #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5,
   parameter bit          BYPASS = 1'b1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] wa,
   input  logic [DATA_W-1:0] wd,
   input  logic [ADDR_W-1:0] ra1,
   input  logic [ADDR_W-1:0] ra2,
   output logic [DATA_W-1:0] rd1,
   output logic [DATA_W-1:0] rd2,
   output logic              wb_valid,
   output logic [ADDR_W-1:0] wb_addr,
   output logic [DATA_W-1:0] wb_data
);

   localparam int unsigned NumRegs = 2 ** ADDR_W;

   logic [NumRegs-1:0] wr_en;
   logic               commit;

   logic [DATA_W-1:0]  regs_q [NumRegs];
   logic [DATA_W-1:0]  regs_d [NumRegs];

   logic               wb_valid_q, wb_valid_d;
   logic [ADDR_W-1:0]  wb_addr_q,  wb_addr_d;
   logic [DATA_W-1:0]  wb_data_q,  wb_data_d;

   // Write demux: one-hot decode of wa qualified by we; index 0 never enabled.
   always_comb begin
      wr_en     = '0;
      wr_en[wa] = we;
      wr_en[0]  = 1'b0;
   end

   assign commit = |wr_en;

   always_comb begin
      for (int i = 0; i < NumRegs; i++) begin
         regs_d[i] = wr_en[i] ? wd : regs_q[i];
      end
      regs_d[0] = '0;
   end

   // Trace address/data hold their last committed values between writes.
   always_comb begin
      wb_valid_d = commit;
      wb_addr_d  = commit ? wa : wb_addr_q;
      wb_data_d  = commit ? wd : wb_data_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NumRegs; i++) begin
            regs_q[i] <= '0;
         end
         wb_valid_q <= 1'b0;
         wb_addr_q  <= '0;
         wb_data_q  <= '0;
      end else begin
         for (int i = 0; i < NumRegs; i++) begin
            regs_q[i] <= regs_d[i];
         end
         wb_valid_q <= wb_valid_d;
         wb_addr_q  <= wb_addr_d;
         wb_data_q  <= wb_data_d;
      end
   end

   // Bypass is gated by reset_n so that every read returns 0 while reset is held,
   // even if a write is being presented.
   always_comb begin
      rd1 = regs_q[ra1];
      if (BYPASS && reset_n && we && (wa == ra1)) begin
         rd1 = wd;
      end
      if (ra1 == '0) begin
         rd1 = '0;
      end
   end

   always_comb begin
      rd2 = regs_q[ra2];
      if (BYPASS && reset_n && we && (wa == ra2)) begin
         rd2 = wd;
      end
      if (ra2 == '0) begin
         rd2 = '0;
      end
   end

   assign wb_valid = wb_valid_q;
   assign wb_addr  = wb_addr_q;
   assign wb_data  = wb_data_q;

endmodule

// File: tb/tb_grf_write_demux.sv
// Bench for grf_write_demux: one BYPASS=1 and one BYPASS=0 instance share all inputs and are
// compared against a register-array model with an explicit write trace.

module tb_grf_write_demux;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        we = 1'b0;
   logic [4:0]  wa = '0;
   logic [31:0] wd = '0;
   logic [4:0]  ra1 = '0;
   logic [4:0]  ra2 = '0;

   logic [31:0] rd1_b, rd2_b, wb_data_b;
   logic [31:0] rd1_n, rd2_n, wb_data_n;
   logic [4:0]  wb_addr_b, wb_addr_n;
   logic        wb_valid_b, wb_valid_n;

   int errors = 0;
   int checks = 0;

   // Reference model state
   logic [31:0] mem [32];
   logic        exp_valid;
   logic [4:0]  exp_addr;
   logic [31:0] exp_data;

   always #5 clk = ~clk;

   grf_write_demux #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1)) u_dut_byp (
      .clk      (clk),
      .reset_n  (reset_n),
      .we       (we),
      .wa       (wa),
      .wd       (wd),
      .ra1      (ra1),
      .ra2      (ra2),
      .rd1      (rd1_b),
      .rd2      (rd2_b),
      .wb_valid (wb_valid_b),
      .wb_addr  (wb_addr_b),
      .wb_data  (wb_data_b)
   );

   grf_write_demux #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0)) u_dut_nob (
      .clk      (clk),
      .reset_n  (reset_n),
      .we       (we),
      .wa       (wa),
      .wd       (wd),
      .ra1      (ra1),
      .ra2      (ra2),
      .rd1      (rd1_n),
      .rd2      (rd2_n),
      .wb_valid (wb_valid_n),
      .wb_addr  (wb_addr_n),
      .wb_data  (wb_data_n)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] model_read(input logic [4:0] ra, input bit byp);
      if (!reset_n || ra == 5'd0) return 32'd0;
      if (byp && we && wa == ra) return wd;
      return mem[ra];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) mem[i] = 32'd0;
      exp_valid = 1'b0;
      exp_addr  = '0;
      exp_data  = '0;
   endtask

   task automatic check_reads(input string tag);
      check_val({tag, ":rd1_byp"}, rd1_b, model_read(ra1, 1'b1));
      check_val({tag, ":rd2_byp"}, rd2_b, model_read(ra2, 1'b1));
      check_val({tag, ":rd1_nob"}, rd1_n, model_read(ra1, 1'b0));
      check_val({tag, ":rd2_nob"}, rd2_n, model_read(ra2, 1'b0));
   endtask

   task automatic check_trace(input string tag);
      check_val({tag, ":wb_valid_byp"}, {31'd0, wb_valid_b}, {31'd0, exp_valid});
      check_val({tag, ":wb_addr_byp"},  {27'd0, wb_addr_b},  {27'd0, exp_addr});
      check_val({tag, ":wb_data_byp"},  wb_data_b, exp_data);
      check_val({tag, ":wb_valid_nob"}, {31'd0, wb_valid_n}, {31'd0, exp_valid});
      check_val({tag, ":wb_addr_nob"},  {27'd0, wb_addr_n},  {27'd0, exp_addr});
      check_val({tag, ":wb_data_nob"},  wb_data_n, exp_data);
   endtask

   // Called 1 time unit after a rising edge; returns 1 time unit after the next one.
   task automatic cycle(input string tag, input logic w, input logic [4:0] a, input logic [31:0] d,
                        input logic [4:0] r1, input logic [4:0] r2);
      we = w; wa = a; wd = d; ra1 = r1; ra2 = r2;
      #2;
      check_reads(tag);
      @(posedge clk);
      if (w && a != 5'd0) begin
         mem[a]    = d;
         exp_valid = 1'b1;
         exp_addr  = a;
         exp_data  = d;
      end else begin
         exp_valid = 1'b0;
      end
      #1;
      check_trace(tag);
   endtask

   initial begin
      logic [4:0] a, r1, r2;
      model_reset();

      // Reset held: scan both ports, also with a write presented.
      #2;
      for (int i = 0; i < 32; i++) begin
         ra1 = 5'(i); ra2 = 5'(31 - i);
         we = (i % 2 == 1); wa = 5'(i); wd = 32'hFFFF_0000 | 32'(i);
         #1;
         check_reads("rst_scan");
      end
      check_trace("rst_trace");
      @(posedge clk); #1;
      check_trace("rst_after_edge");
      we = 1'b0;

      // Release between edges.
      #2 reset_n = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 32; i++) cycle("post_rst_scan", 1'b0, 5'd0, 32'd0, 5'(i), 5'(31 - i));

      // Write and read back.
      cycle("wr8", 1'b1, 5'd8, 32'hDEAD_BEEF, 5'd8, 5'd8);
      cycle("rd8", 1'b0, 5'd0, 32'd0, 5'd8, 5'd8);
      cycle("rd8_idle", 1'b0, 5'd0, 32'd0, 5'd8, 5'd0);

      // Register 0 protection.
      cycle("wr0", 1'b1, 5'd0, 32'h1234_5678, 5'd0, 5'd0);
      cycle("rd0", 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);

      // Bypass vs stored value.
      cycle("byp17", 1'b1, 5'd17, 32'hA5A5_A5A5, 5'd17, 5'd17);
      cycle("rd17", 1'b0, 5'd0, 32'd0, 5'd17, 5'd17);

      // Back-to-back writes to the same index.
      cycle("b2b_a", 1'b1, 5'd9, 32'h1111_1111, 5'd9, 5'd8);
      cycle("b2b_b", 1'b1, 5'd9, 32'h2222_2222, 5'd9, 5'd8);
      cycle("b2b_rd", 1'b0, 5'd0, 32'd0, 5'd9, 5'd9);

      // Demux isolation.
      for (int k = 1; k < 32; k++) cycle("iso_wr", 1'b1, 5'(k), 32'(k) * 32'h0101_0101, 5'(k - 1), 5'(k));
      for (int k = 0; k < 32; k++) begin
         cycle("iso_rd", 1'b0, 5'(k), 32'hBAD0_0000, 5'(k), 5'(31 - k));
         check_val("iso_val", rd1_n, (k == 0) ? 32'd0 : 32'(k) * 32'h0101_0101);
      end

      // Randomized traffic.
      for (int n = 0; n < 400; n++) begin
         a  = 5'($urandom_range(0, 31));
         r1 = ($urandom_range(0, 3) == 0) ? a : 5'($urandom_range(0, 31));
         r2 = ($urandom_range(0, 3) == 0) ? a : 5'($urandom_range(0, 31));
         cycle("rand", 1'($urandom_range(0, 1)), a, $urandom, r1, r2);
      end

      // Async reset mid-operation.
      cycle("ar_wr3", 1'b1, 5'd3, 32'h0000_0001, 5'd3, 5'd3);
      we = 1'b0; ra1 = 5'd3; ra2 = 5'd3;
      #2;
      check_reads("ar_pre");
      reset_n = 1'b0;
      model_reset();
      #1;
      check_reads("ar_during");
      check_trace("ar_trace");
      we = 1'b1; wa = 5'd3; wd = 32'h0000_0007;
      @(posedge clk); #1;
      check_reads("ar_edge");
      check_trace("ar_edge_trace");
      #2 we = 1'b0;
      reset_n = 1'b1;
      @(posedge clk); #1;
      cycle("ar_after", 1'b0, 5'd0, 32'd0, 5'd3, 5'd3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
